gpc206_4_checker: RTL and testbench
===================================

// Module: gpc206_4_checker
// PURPOSE
//  Synthesizable response checker for the GPC (6,0,2;4) compressor (weights: 6 x w1, 2 x w4).
//  Gets the same src0/src2 stimulus as the DUT and computes the reference weighted sum.
//  Holds that sum through a delay line matched to the DUT latency, then compares it with dst.
//  Counts samples and mismatches. Sits next to the GPC under test in FPGA self-test and in sim.
// PARAMETERS
//  DUT_LAT  1   DUT latency in cycles from stimulus to valid dst; legal 0..8
//  CNT_W    16  width of sample and error counters; counters saturate at all-ones
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      asynchronous, active-high reset
//  stim_valid     in   1      src0/src2 carry a stimulus this cycle (sample applied to DUT)
//  src0           in   6      weight-1 inputs
//  src2           in   2      weight-4 inputs
//  dut_dst        in   4      DUT result, sampled DUT_LAT cycles after its stim_valid
//  clear          in   1      synchronous clear of counters/sticky/capture
//  chk_valid      out  1      a comparison completed this cycle
//  mismatch       out  1      comparison failed (qualified by chk_valid)
//  fail           out  1      sticky: any mismatch since reset/clear
//  sample_cnt     out  CNT_W  number of comparisons done
//  err_cnt        out  CNT_W  number of mismatches
//  ff_exp         out  4      expected sum of first failure (capture feature)
//  ff_got         out  4      DUT value of first failure (capture feature)
// BEHAVIOUR
//  Reference: exp = popcount(src0) + 4*popcount(src2), 4-bit, range 0..14. No overflow possible.
//  Delay line: DUT_LAT stages of {valid, exp[3:0]}, advancing every cycle (no stall).
//   DUT_LAT=0 -> compare exp against dut_dst in the same cycle as stim_valid.
//  Compare stage is registered. Stimulus at cycle t gives dut_dst sampled at t+DUT_LAT.
//   chk_valid and mismatch are asserted at t+DUT_LAT+1, single-cycle pulses.
//   Throughput is 1 sample/cycle. Back-to-back stim_valid is legal.
//  On each compare: sample_cnt+1. If exp != dut_dst, err_cnt+1 and fail<=1.
//   Both counters saturate at 2**CNT_W-1 (no wrap).
//  clear: zeroes sample_cnt, err_cnt, fail, ff_*, and the capture-armed flag.
//   Delay line is NOT flushed, so in-flight samples are still checked after clear.
//   If clear coincides with a compare, clear wins: that compare is not counted, and no
//   capture is taken. chk_valid/mismatch still pulse for it.
//  rst (async): every output 0, all delay-line valid bits 0, capture re-armed.
//   Deassertion mid-traffic: only stim_valid seen after release is checked.
//  stim_valid=0 cycles create bubbles. dut_dst is ignored in bubble slots.
// CONFIGURATION
//  GPC_CHK_FIRSTFAIL_EN defined: on the first counted mismatch, ff_exp<=exp and ff_got<=dut_dst.
//   Both hold until rst/clear; later mismatches do not overwrite them.
//  Not defined: no capture registers; ff_exp and ff_got are tied to 0.
// STRUCTURE
//  Package gpc_pkg: localparams W0_N=6, W2_N=2, W2_WEIGHT=4, SUM_W=4.
//   Also typedef logic [SUM_W-1:0] gpc_sum_t and function gpc206_ref(src0,src2).
//  Sub-module gpc_chk_delay (parameter DEPTH, WIDTH): valid+data shift register with async reset.
//   DEPTH=0 is a pass-through. Everything else is in the top.
// TESTING
//  1 DUT_LAT=1, single stim src0=6'h03 src2=2'h3, dut_dst=4'hA at t+1 ->
//    chk_valid at t+2, mismatch=0, sample_cnt=1, err_cnt=0.
//  2 Back-to-back 20 vectors, correct DUT model (e.g. 6'h3f/3->E, 6'h00/2->4, 6'h33/0->4) ->
//    20 chk_valid pulses on consecutive cycles, err_cnt=0, fail=0.
//  3 Fault injection: src0=6'h0e src2=2'h3 expect B, force dut_dst=4'h9 ->
//    mismatch=1, fail=1, err_cnt=1, ff_exp=B, ff_got=9 with GPC_CHK_FIRSTFAIL_EN.
//    A second fault leaves ff_* unchanged. Without the macro, ff_*=0.
//  4 clear asserted on the same cycle as a faulty compare ->
//    counters 0 and fail 0 after that cycle. The next in-flight compare is counted as sample_cnt=1.
//  5 CNT_W=4, 20 faulty samples -> err_cnt and sample_cnt stick at 4'hF.
//  6 rst pulse mid-stream with 3 samples in flight (DUT_LAT=3) ->
//    all outputs 0 at once, no chk_valid for those 3 samples.
//    DUT_LAT=0 sweep of all 256 inputs -> err_cnt=0.

Source files
------------

// File: rtl/gpc206_4_checker_pkg.sv
// Shared constants, sum type and reference model for the GPC (6,0,2;4) response checker.
package gpc_pkg;

  localparam int unsigned W0_N      = 6;
  localparam int unsigned W2_N      = 2;
  localparam int unsigned W2_WEIGHT = 4;
  localparam int unsigned SUM_W     = 4;

  typedef logic [SUM_W-1:0] gpc_sum_t;

  // Weighted popcount: six weight-1 bits plus two weight-4 bits, max 14.
  function automatic gpc_sum_t gpc206_ref(input logic [W0_N-1:0] src0,
                                          input logic [W2_N-1:0] src2);
    gpc_sum_t s;
    s = '0;
    for (int unsigned i = 0; i < W0_N; i++) begin
      s = s + gpc_sum_t'(src0[i]);
    end
    for (int unsigned i = 0; i < W2_N; i++) begin
      if (src2[i]) begin
        s = s + gpc_sum_t'(W2_WEIGHT);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/gpc206_4_checker_delay.sv
// gpc_chk_delay: valid+data shift register, advances every cycle; DEPTH=0 is a wire.
module gpc_chk_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_valid = i_valid;
      assign o_data  = i_data;
    end else begin : g_pipe
      logic             r_vld [DEPTH];
      logic [WIDTH-1:0] r_dat [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < DEPTH; k++) begin
            r_vld[k] <= 1'b0;
            r_dat[k] <= '0;
          end
        end else begin
          r_vld[0] <= i_valid;
          r_dat[0] <= i_data;
          for (int unsigned k = 1; k < DEPTH; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_dat[k] <= r_dat[k-1];
          end
        end
      end

      assign o_valid = r_vld[DEPTH-1];
      assign o_data  = r_dat[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/gpc206_4_checker.sv
// Response checker for the GPC (6,0,2;4): latency-matched reference compare with counters.
// Optional first-failure capture of expected/got values: define GPC_CHK_FIRSTFAIL_EN.
module gpc206_4_checker
  import gpc_pkg::*;
#(
  parameter int unsigned DUT_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stim_valid,
  input  logic [W0_N-1:0]   src0,
  input  logic [W2_N-1:0]   src2,
  input  logic [SUM_W-1:0]  dut_dst,
  input  logic              clear,
  output logic              chk_valid,
  output logic              mismatch,
  output logic              fail,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [SUM_W-1:0]  ff_exp,
  output logic [SUM_W-1:0]  ff_got
);

  gpc_sum_t         w_exp;
  gpc_sum_t         w_dl_exp;
  logic             w_dl_valid;
  logic             w_mism;
  logic             w_count;

  logic             r_chk_valid;
  logic             r_mismatch;
  logic             r_fail;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_exp = gpc206_ref(src0, src2);

  gpc_chk_delay #(
    .DEPTH (DUT_LAT),
    .WIDTH (SUM_W)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .i_valid (stim_valid),
    .i_data  (w_exp),
    .o_valid (w_dl_valid),
    .o_data  (w_dl_exp)
  );

  // dut_dst is only meaningful in slots where the delay line carries a valid sample.
  assign w_mism  = w_dl_valid && (w_dl_exp != dut_dst);
  assign w_count = w_dl_valid && !clear;

  // Result pulses fire for every compare, even one swallowed by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_valid <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_chk_valid <= w_dl_valid;
      r_mismatch  <= w_mism;
    end
  end

  // Saturating counters and sticky fail; clear wins over a coincident compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_fail       <= 1'b0;
    end else if (clear) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_fail       <= 1'b0;
    end else if (w_dl_valid) begin
      if (r_sample_cnt != '1) begin
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      end
      if (w_mism) begin
        r_fail <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef GPC_CHK_FIRSTFAIL_EN
  gpc_sum_t r_ff_exp;
  gpc_sum_t r_ff_got;
  logic     r_ff_taken;

  // Capture only the first counted mismatch; re-armed by rst or clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
      r_ff_taken <= 1'b0;
    end else if (clear) begin
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
      r_ff_taken <= 1'b0;
    end else if (w_count && w_mism && !r_ff_taken) begin
      r_ff_exp   <= w_dl_exp;
      r_ff_got   <= dut_dst;
      r_ff_taken <= 1'b1;
    end
  end

  assign ff_exp = r_ff_exp;
  assign ff_got = r_ff_got;
`else
  assign ff_exp = '0;
  assign ff_got = '0;
`endif

  assign chk_valid  = r_chk_valid;
  assign mismatch   = r_mismatch;
  assign fail       = r_fail;
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_gpc206_4_checker.sv
// Bench for gpc206_4_checker: three instances (latency 0/1/3) checked every cycle against a behavioural model.
module tb_gpc206_4_checker;

  localparam int NI   = 3;
  localparam int MAXC = 1024;
  localparam int LAT [NI] = '{0, 1, 3};
  localparam int MAXV[NI] = '{65535, 65535, 15};
`ifdef GPC_CHK_FIRSTFAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       stim_valid;
  logic [5:0] src0;
  logic [1:0] src2;
  logic       clear;
  logic [3:0] dst [NI];

  logic [NI-1:0] cv, mm, fl;
  logic [15:0]   sc0, ec0, sc1, ec1;
  logic [3:0]    sc2, ec2;
  logic [3:0]    fe0, fg0, fe1, fg1, fe2, fg2;
  int a_sc[NI], a_ec[NI], a_fe[NI], a_fg[NI];

  assign a_sc[0] = int'(sc0);  assign a_sc[1] = int'(sc1);  assign a_sc[2] = int'(sc2);
  assign a_ec[0] = int'(ec0);  assign a_ec[1] = int'(ec1);  assign a_ec[2] = int'(ec2);
  assign a_fe[0] = int'(fe0);  assign a_fe[1] = int'(fe1);  assign a_fe[2] = int'(fe2);
  assign a_fg[0] = int'(fg0);  assign a_fg[1] = int'(fg1);  assign a_fg[2] = int'(fg2);

  always #5 clk = ~clk;

  gpc206_4_checker #(.DUT_LAT(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .stim_valid(stim_valid), .src0(src0), .src2(src2),
    .dut_dst(dst[0]), .clear(clear), .chk_valid(cv[0]), .mismatch(mm[0]), .fail(fl[0]),
    .sample_cnt(sc0), .err_cnt(ec0), .ff_exp(fe0), .ff_got(fg0));

  gpc206_4_checker #(.DUT_LAT(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .stim_valid(stim_valid), .src0(src0), .src2(src2),
    .dut_dst(dst[1]), .clear(clear), .chk_valid(cv[1]), .mismatch(mm[1]), .fail(fl[1]),
    .sample_cnt(sc1), .err_cnt(ec1), .ff_exp(fe1), .ff_got(fg1));

  gpc206_4_checker #(.DUT_LAT(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .stim_valid(stim_valid), .src0(src0), .src2(src2),
    .dut_dst(dst[2]), .clear(clear), .chk_valid(cv[2]), .mismatch(mm[2]), .fail(fl[2]),
    .sample_cnt(sc2), .err_cnt(ec2), .ff_exp(fe2), .ff_got(fg2));

  // Per-cycle stimulus history: cycle c is sampled by the posedge that ends it.
  bit h_val[MAXC], h_flt[MAXC], h_clr[MAXC], h_rst[MAXC];
  int h_ref[MAXC];
  int h_dst[NI][MAXC];
  int cyc = 0;

  int n_chk = 0;
  int n_err = 0;

  // Model state
  int m_sc[NI], m_ec[NI], m_fe[NI], m_fg[NI];
  bit m_cv[NI], m_mm[NI], m_fl[NI], m_armed[NI];

  function automatic int ref_sum(input logic [5:0] a, input logic [1:0] b);
    return $countones(a) + 4 * $countones(b);
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs and the bench-side "GPC under test" results.
  task automatic drive(input bit v, input logic [5:0] a, input logic [1:0] b,
                       input bit flt, input bit clr, input bit r);
    int s;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    stim_valid = v; src0 = a; src2 = b; clear = clr; rst = r;
    h_val[cyc] = v; h_flt[cyc] = flt; h_clr[cyc] = clr; h_rst[cyc] = r;
    h_ref[cyc] = ref_sum(a, b);
    for (int k = 0; k < NI; k++) begin
      s = cyc - LAT[k];
      if (s >= 0 && h_val[s])
        dst[k] = 4'(h_ref[s] ^ (h_flt[s] ? 2 : 0));
      else
        dst[k] = 4'($urandom_range(0, 15));
      h_dst[k][cyc] = int'(dst[k]);
    end
  endtask

  task automatic go(input bit v, input logic [5:0] a, input logic [1:0] b,
                    input bit flt = 1'b0, input bit clr = 1'b0, input bit r = 1'b0);
    @(negedge clk);
    drive(v, a, b, flt, clr, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 6'($urandom), 2'($urandom));
    #2;
  endtask

  // Model step and compare for every instance after each rising edge.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NI; k++) begin
      int  s;
      bit  v;
      bit  m;
      if (h_rst[cyc]) begin
        m_cv[k] = 0; m_mm[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_ec[k] = 0;
        m_fe[k] = 0; m_fg[k] = 0; m_armed[k] = 1;
      end else begin
        s = cyc - LAT[k];
        v = 0;
        if (s >= 0) v = h_val[s];
        if (v) for (int j = s; j <= cyc; j++) if (h_rst[j]) v = 0;
        m = v && (h_ref[s] != h_dst[k][cyc]);
        m_cv[k] = v;
        m_mm[k] = m;
        if (h_clr[cyc]) begin
          m_sc[k] = 0; m_ec[k] = 0; m_fl[k] = 0; m_fe[k] = 0; m_fg[k] = 0; m_armed[k] = 1;
        end else if (v) begin
          if (m_sc[k] < MAXV[k]) m_sc[k]++;
          if (m) begin
            if (m_ec[k] < MAXV[k]) m_ec[k]++;
            m_fl[k] = 1;
            if (FF_EN && m_armed[k]) begin
              m_fe[k] = h_ref[s]; m_fg[k] = h_dst[k][cyc]; m_armed[k] = 0;
            end
          end
        end
      end
      check($sformatf("c%0d u%0d chk_valid", cyc, k), int'(cv[k]), int'(m_cv[k]));
      check($sformatf("c%0d u%0d mismatch", cyc, k), int'(mm[k]), int'(m_mm[k]));
      check($sformatf("c%0d u%0d fail", cyc, k), int'(fl[k]), int'(m_fl[k]));
      check($sformatf("c%0d u%0d sample_cnt", cyc, k), a_sc[k], m_sc[k]);
      check($sformatf("c%0d u%0d err_cnt", cyc, k), a_ec[k], m_ec[k]);
      check($sformatf("c%0d u%0d ff_exp", cyc, k), a_fe[k], m_fe[k]);
      check($sformatf("c%0d u%0d ff_got", cyc, k), a_fg[k], m_fg[k]);
    end
    cyc++;
  end

  initial begin
    for (int k = 0; k < NI; k++) m_armed[k] = 1;
    drive(1'b0, 6'h00, 2'h0, 1'b0, 1'b0, 1'b1);
    go(1'b0, 6'h00, 2'h0, 1'b0, 1'b0, 1'b1);
    go(1'b0, 6'h00, 2'h0, 1'b0, 1'b0, 1'b1);
    #2;
    check("lit_reset_sc1", a_sc[1], 0);
    check("lit_reset_cv", int'(cv), 0);
    idle(3);

    // single stimulus 03/3 -> A
    go(1'b1, 6'h03, 2'h3);
    idle(4);
    check("lit_t1_sc1", a_sc[1], 1);
    check("lit_t1_ec1", a_ec[1], 0);
    check("lit_t1_sc3", a_sc[2], 1);

    // 20 back-to-back correct vectors
    go(1'b1, 6'h3f, 2'h3);
    go(1'b1, 6'h00, 2'h2);
    go(1'b1, 6'h33, 2'h0);
    for (int i = 3; i < 20; i++) go(1'b1, 6'(i * 13 + 5), 2'(i));
    idle(4);
    check("lit_t2_sc1", a_sc[1], 21);
    check("lit_t2_ec1", a_ec[1], 0);
    check("lit_t2_fail1", int'(fl[1]), 0);
    check("lit_t2_sc3_sat", a_sc[2], 15);

    // fault: 0e/3 expects B, DUT returns 9
    go(1'b1, 6'h0e, 2'h3, 1'b1);
    idle(4);
    check("lit_t3_ec1", a_ec[1], 1);
    check("lit_t3_fail1", int'(fl[1]), 1);
    check("lit_t3_ffexp1", a_fe[1], FF_EN ? 11 : 0);
    check("lit_t3_ffgot1", a_fg[1], FF_EN ? 9 : 0);
    go(1'b1, 6'h3f, 2'h0, 1'b1);
    idle(4);
    check("lit_t3b_ec1", a_ec[1], 2);
    check("lit_t3b_ffexp1", a_fe[1], FF_EN ? 11 : 0);
    check("lit_t3b_ffgot1", a_fg[1], FF_EN ? 9 : 0);

    // clear on the cycle of a faulty compare for the latency-1 instance
    go(1'b1, 6'h15, 2'h1, 1'b1);
    go(1'b1, 6'h2a, 2'h2, 1'b0, 1'b1);
    idle(4);
    check("lit_t4_sc1", a_sc[1], 1);
    check("lit_t4_ec1", a_ec[1], 0);
    check("lit_t4_fail1", int'(fl[1]), 0);
    check("lit_t4_ffexp1", a_fe[1], 0);
    check("lit_t4_sc0", a_sc[0], 0);
    check("lit_t4_sc3", a_sc[2], 2);
    check("lit_t4_ec3", a_ec[2], 1);
    check("lit_t4_ffexp3", a_fe[2], FF_EN ? 7 : 0);
    check("lit_t4_ffgot3", a_fg[2], FF_EN ? 5 : 0);

    // saturation with 20 faulty samples
    for (int i = 0; i < 20; i++) go(1'b1, 6'(i * 7), 2'(i + 1), 1'b1);
    idle(4);
    check("lit_t5_sc3", a_sc[2], 15);
    check("lit_t5_ec3", a_ec[2], 15);
    check("lit_t5_ec1", a_ec[1], 20);

    // reset with three samples in flight in the latency-3 instance
    go(1'b1, 6'h01, 2'h0);
    go(1'b1, 6'h02, 2'h1);
    go(1'b1, 6'h04, 2'h2);
    go(1'b0, 6'h00, 2'h0, 1'b0, 1'b0, 1'b1);
    #2;
    check("lit_t6_sc3_now", a_sc[2], 0);
    check("lit_t6_ec3_now", a_ec[2], 0);
    check("lit_t6_fail3_now", int'(fl[2]), 0);
    check("lit_t6_sc1_now", a_sc[1], 0);
    go(1'b0, 6'h00, 2'h0, 1'b0, 1'b0, 1'b1);
    idle(6);
    check("lit_t6_sc3_after", a_sc[2], 0);

    // full input sweep
    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      w = 8'(i);
      go(1'b1, w[5:0], w[7:6]);
    end
    idle(4);
    check("lit_sweep_sc0", a_sc[0], 256);
    check("lit_sweep_ec0", a_ec[0], 0);
    check("lit_sweep_sc1", a_sc[1], 256);
    check("lit_sweep_sc3", a_sc[2], 15);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
